// File: rtl/pad_pkg.sv
// pad_pkg: shared definitions for the paddle controller.
//   pad_state_e : per-paddle movement state (IDLE / UP / DOWN)
//   KEY_DOWN/UP : bit index of each key inside a channel's 2-bit key pair
//   *_DEF       : default playfield geometry and movement constants
package pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } pad_state_e;

  localparam int KEY_DOWN = 0;
  localparam int KEY_UP   = 1;

  localparam int PAD_W_DEF  = 5;
  localparam int PAD_H_DEF  = 70;
  localparam int Y_MIN_DEF  = 5;
  localparam int Y_MAX_DEF  = 400;
  localparam int Y_INIT_DEF = 205;

endpackage

// File: rtl/pad_chan.sv
// pad_chan: one paddle channel.
//   vga_clk, sys_rst_n (sync, active-high), start, move_en : timing/control
//   key_n[1:0]  : active-low key pair (KEY_DOWN = +y, KEY_UP = -y)
//   auto_mode   : track ball_y instead of keys
//   pad_x       : paddle left x; body_x/body_y : current pixel
//   hit         : combinational pixel-inside-paddle (feeds the shared OR register)
//   head        : registered hit; pad_y : current paddle top
module pad_chan
  import pad_pkg::*;
#(
  parameter int COORD_W     = 12,
  parameter int PAD_W       = PAD_W_DEF,
  parameter int PAD_H       = PAD_H_DEF,
  parameter int Y_MIN       = Y_MIN_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int Y_INIT      = Y_INIT_DEF,
  parameter int STEP        = 10,
  parameter int STEP_FAST   = 20,
  parameter int ACCEL_TICKS = 4,
  parameter int DEADBAND    = 8
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic               move_en,
  input  logic [1:0]         key_n,
  input  logic               auto_mode,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] pad_x,
  input  logic [COORD_W-1:0] body_x,
  input  logic [COORD_W-1:0] body_y,
  output logic               hit,
  output logic               head,
  output logic [COORD_W-1:0] pad_y
);

  localparam int CW1 = COORD_W + 1;
  localparam int HW  = $clog2(ACCEL_TICKS + 1);

  pad_state_e         state_q, state_d, req;
  logic [HW-1:0]      hold_q, hold_d;
  logic [COORD_W-1:0] y_q, y_d, y_move;
  logic [CW1-1:0]     centre, ball_w, step, sum;
  logic               same, fast;

  // Direction request. Auto-mode compares are rearranged so nothing is
  // subtracted from the centre (no underflow near the top of the field).
  always_comb begin
    req    = ST_IDLE;
    ball_w = {1'b0, ball_y};
    centre = {1'b0, y_q} + CW1'(PAD_H / 2);
    if (auto_mode) begin
      if (ball_w + CW1'(DEADBAND) < centre)      req = ST_UP;
      else if (ball_w > centre + CW1'(DEADBAND)) req = ST_DOWN;
    end else if (!key_n[KEY_DOWN] && key_n[KEY_UP]) begin
      req = ST_DOWN;
    end else if (key_n[KEY_DOWN] && !key_n[KEY_UP]) begin
      req = ST_UP;
    end
  end

  // hold_q counts consecutive moves in the current direction; a move out of
  // IDLE or a reversal is the first move of a new run, so it loads 1 and is
  // taken at STEP. STEP_FAST applies once ACCEL_TICKS moves have been made.
  always_comb begin
    same   = (req == state_q) && (req != ST_IDLE);
    fast   = same && (hold_q >= HW'(ACCEL_TICKS));
    step   = fast ? CW1'(STEP_FAST) : CW1'(STEP);
    sum    = {1'b0, y_q} + step;
    y_move = y_q;
    case (req)
      ST_DOWN: y_move = (sum > CW1'(Y_MAX)) ? COORD_W'(Y_MAX) : sum[COORD_W-1:0];
      ST_UP:   y_move = ({1'b0, y_q} < CW1'(Y_MIN) + step) ? COORD_W'(Y_MIN)
                                                             : y_q - step[COORD_W-1:0];
      default: y_move = y_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = y_q;
    if (!start) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      y_d     = COORD_W'(Y_INIT);
    end else if (move_en) begin
      state_d = req;
      y_d     = y_move;
      if (req == ST_IDLE)                     hold_d = '0;
      else if (!same)                         hold_d = HW'(1);
      else if (hold_q != HW'(ACCEL_TICKS))    hold_d = hold_q + HW'(1);
    end
  end

  // Hit test against the pre-update position; all bounds strict.
  always_comb begin
    hit = ({1'b0, body_x} > {1'b0, pad_x}) &&
          ({1'b0, body_x} < {1'b0, pad_x} + CW1'(PAD_W)) &&
          ({1'b0, body_y} > {1'b0, y_q}) &&
          ({1'b0, body_y} < {1'b0, y_q} + CW1'(PAD_H));
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      y_q     <= COORD_W'(Y_INIT);
      head    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      head    <= hit;
    end
  end

  assign pad_y = y_q;

endmodule

// File: rtl/pad_ctrl_multi.sv
// pad_ctrl_multi: NUM_PADS independent paddle channels on vga_clk.
//   vga_clk, sys_rst_n (sync, active-high), start, move_en
//   key_n[2i]/[2i+1] : channel i down/up (active low)
//   auto_mode[i], ball_y : ball tracking
//   pad_x slice i, body_x, body_y : hit-test inputs
//   head[i], hit_any : registered hit flags; pad_y slice i : paddle top
module pad_ctrl_multi
  import pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int COORD_W     = 12,
  parameter int PAD_W       = PAD_W_DEF,
  parameter int PAD_H       = PAD_H_DEF,
  parameter int Y_MIN       = Y_MIN_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int Y_INIT      = Y_INIT_DEF,
  parameter int STEP        = 10,
  parameter int STEP_FAST   = 20,
  parameter int ACCEL_TICKS = 4,
  parameter int DEADBAND    = 8
) (
  input  logic                        vga_clk,
  input  logic                        sys_rst_n,
  input  logic                        start,
  input  logic                        move_en,
  input  logic [2*NUM_PADS-1:0]       key_n,
  input  logic [NUM_PADS-1:0]         auto_mode,
  input  logic [COORD_W-1:0]          ball_y,
  input  logic [NUM_PADS*COORD_W-1:0] pad_x,
  input  logic [COORD_W-1:0]          body_x,
  input  logic [COORD_W-1:0]          body_y,
  output logic [NUM_PADS-1:0]         head,
  output logic [NUM_PADS*COORD_W-1:0] pad_y,
  output logic                        hit_any
);

  logic [NUM_PADS-1:0] hit_c;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_chan
    pad_chan #(
      .COORD_W(COORD_W), .PAD_W(PAD_W), .PAD_H(PAD_H),
      .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT),
      .STEP(STEP), .STEP_FAST(STEP_FAST),
      .ACCEL_TICKS(ACCEL_TICKS), .DEADBAND(DEADBAND)
    ) u_chan (
      .vga_clk  (vga_clk),
      .sys_rst_n(sys_rst_n),
      .start    (start),
      .move_en  (move_en),
      .key_n    (key_n[2*g +: 2]),
      .auto_mode(auto_mode[g]),
      .ball_y   (ball_y),
      .pad_x    (pad_x[g*COORD_W +: COORD_W]),
      .body_x   (body_x),
      .body_y   (body_y),
      .hit      (hit_c[g]),
      .head     (head[g]),
      .pad_y    (pad_y[g*COORD_W +: COORD_W])
    );
  end

  // Built from the unregistered hits so it lands on the same edge as head.
  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) hit_any <= 1'b0;
    else           hit_any <= |hit_c;
  end

endmodule

// File: tb/tb_pad_ctrl_multi.sv
module tb_pad_ctrl_multi;

  localparam int NP = 2;
  localparam int CW = 12;

  logic              vga_clk = 1'b0;
  logic              sys_rst_n, start, move_en;
  logic [2*NP-1:0]   key_n;
  logic [NP-1:0]     auto_mode;
  logic [CW-1:0]     ball_y, body_x, body_y;
  logic [NP*CW-1:0]  pad_x;
  logic [NP-1:0]     head;
  logic [NP*CW-1:0]  pad_y;
  logic              hit_any;

  int tests = 0;
  int fails = 0;

  // Reference model: position, last move direction (-1/0/+1) and length of
  // the current same-direction run of moves.
  int m_y[NP], m_dir[NP], m_run[NP], m_head[NP];
  bit m_any;

  pad_ctrl_multi dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .start(start), .move_en(move_en),
    .key_n(key_n), .auto_mode(auto_mode), .ball_y(ball_y), .pad_x(pad_x),
    .body_x(body_x), .body_y(body_y), .head(head), .pad_y(pad_y), .hit_any(hit_any)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int want_dir(int i);
    int c;
    if (auto_mode[i]) begin
      c = m_y[i] + 35;
      if (int'(ball_y) < c - 8) return -1;
      if (int'(ball_y) > c + 8) return 1;
      return 0;
    end
    if (!key_n[2*i] && key_n[2*i+1]) return 1;
    if (key_n[2*i] && !key_n[2*i+1]) return -1;
    return 0;
  endfunction

  // One clock edge: predict from current inputs, advance, check everything.
  task automatic cyc();
    int d, st, px;
    m_any = 0;
    for (int i = 0; i < NP; i++) begin
      px = int'(pad_x[i*CW +: CW]);
      m_head[i] = (!sys_rst_n && int'(body_x) > px && int'(body_x) < px + 5 &&
                   int'(body_y) > m_y[i] && int'(body_y) < m_y[i] + 70) ? 1 : 0;
      if (m_head[i] != 0) m_any = 1;
    end
    for (int i = 0; i < NP; i++) begin
      if (sys_rst_n || !start) begin
        m_y[i] = 205; m_dir[i] = 0; m_run[i] = 0;
      end else if (move_en) begin
        d = want_dir(i);
        if (d == 0) begin
          m_dir[i] = 0; m_run[i] = 0;
        end else begin
          st = (d == m_dir[i] && m_run[i] >= 4) ? 20 : 10;
          m_run[i] = (d == m_dir[i]) ? m_run[i] + 1 : 1;
          m_dir[i] = d;
          m_y[i] = m_y[i] + d * st;
          if (m_y[i] > 400) m_y[i] = 400;
          if (m_y[i] < 5)   m_y[i] = 5;
        end
      end
    end
    @(posedge vga_clk); #1;
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("pad_y%0d", i), int'(pad_y[i*CW +: CW]), m_y[i]);
      chk($sformatf("head%0d", i), int'(head[i]), m_head[i]);
    end
    chk("hit_any", int'(hit_any), int'(m_any));
  endtask

  task automatic strobe();
    move_en = 1'b1; cyc();
    move_en = 1'b0; cyc();
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{215, 225, 235, 245, 265, 285};
    for (int i = 0; i < NP; i++) begin m_y[i] = 205; m_dir[i] = 0; m_run[i] = 0; end
    sys_rst_n = 1'b1; start = 1'b0; move_en = 1'b0; key_n = '1; auto_mode = '0;
    ball_y = '0; body_x = '0; body_y = '0;
    pad_x = {12'd20, 12'd630};

    // reset, second cycle with down key held and a strobe
    cyc();
    key_n = 4'b1110; start = 1'b1; move_en = 1'b1; cyc();
    chk("rst_pad0", int'(pad_y[11:0]), 205);
    chk("rst_head", int'(head), 0);
    move_en = 1'b0; sys_rst_n = 1'b0;

    // manual down x3, pad1 untouched
    repeat (3) strobe();
    chk("down3_pad0", int'(pad_y[11:0]), 235);
    chk("down3_pad1", int'(pad_y[23:12]), 205);
    key_n = 4'b1100; strobe();
    chk("both_keys", int'(pad_y[11:0]), 235);
    key_n = 4'b1110; strobe();
    chk("after_idle_step", int'(pad_y[11:0]), 245);

    // acceleration from 205
    start = 1'b0; cyc(); start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      strobe();
      chk($sformatf("accel%0d", k), int'(pad_y[11:0]), exp_seq[k]);
    end
    // start=0 mid-movement, strobes ignored, then restart at STEP
    start = 1'b0; cyc();
    chk("stop_pad0", int'(pad_y[11:0]), 205);
    strobe();
    start = 1'b1; strobe();
    chk("restart_step", int'(pad_y[11:0]), 215);
    repeat (30) strobe();
    chk("clamp_max", int'(pad_y[11:0]), 400);
    key_n = 4'b1101; repeat (30) strobe();
    chk("clamp_min", int'(pad_y[11:0]), 5);
    key_n = 4'b1110; strobe();
    chk("bottom_down", int'(pad_y[11:0]), 15);
    key_n = 4'b1101; strobe();
    chk("up_exact_min", int'(pad_y[11:0]), 5);

    // auto mode on pad1, its keys scrambled
    key_n = 4'b1111; auto_mode = 2'b10; ball_y = 12'd50;
    for (int k = 0; k < 20; k++) begin
      key_n[3:2] = 2'($urandom);
      strobe();
    end
    chk("auto_settle", int'(pad_y[23:12]), 15);
    auto_mode = '0; key_n = '1;

    // hit boundaries with pad0 at (630,205)
    start = 1'b0; cyc();
    body_x = 12'd632; body_y = 12'd210; cyc();
    chk("hit_in", int'(head[0]), 1);
    chk("hit_any_in", int'(hit_any), 1);
    body_x = 12'd635; cyc(); chk("hit_xr", int'(head[0]), 0);
    body_x = 12'd632; body_y = 12'd205; cyc(); chk("hit_top", int'(head[0]), 0);
    body_y = 12'd274; cyc(); chk("hit_bot_in", int'(head[0]), 1);
    body_y = 12'd275; cyc(); chk("hit_bot_out", int'(head[0]), 0);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      int p;
      sys_rst_n = ($urandom_range(0, 63) == 0);
      start     = ($urandom_range(0, 15) != 0);
      move_en   = $urandom_range(0, 1) == 1;
      key_n     = 4'($urandom);
      auto_mode = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      ball_y    = 12'($urandom_range(0, 480));
      if ($urandom_range(0, 31) == 0) pad_x = {12'($urandom_range(0, 630)), 12'($urandom_range(0, 630))};
      p = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 1) == 1) begin
        body_x = pad_x[p*CW +: CW] + 12'($urandom_range(0, 6));
        body_y = 12'(m_y[p] + $urandom_range(0, 72));
      end else begin
        body_x = 12'($urandom_range(0, 700));
        body_y = 12'($urandom_range(0, 480));
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
